// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port memory shared between instruction fetch and data
// access. Data side has priority; one IDLE cycle always separates grants.
// Optional starvation guard enabled by defining ARB_STARVE_GUARD_EN: after
// STARVE_LIMIT data grants taken while fetch waited, fetch wins the next tie.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_valid,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        stall_f,
    output logic        stall_m
);

    typedef enum logic [1:0] {IDLE, GRANT_IF, GRANT_DM} state_t;

    state_t      r_state;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic        w_pick_if;
    logic        w_pick_dm;

`ifdef ARB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    logic [CW-1:0] r_starve_cnt;
    logic          w_starved;

    assign w_starved = (r_starve_cnt == CW'(STARVE_LIMIT));
    // Fetch wins a tie only once data has hogged the port long enough.
    assign w_pick_if = if_req & (~dm_req | w_starved);
`else
    localparam int unused_starve_limit = STARVE_LIMIT;
    // Strict data priority.
    assign w_pick_if = if_req & ~dm_req;
`endif
    assign w_pick_dm = dm_req & ~w_pick_if;

    // Arbitration FSM; memory-side request fields are latched on grant entry
    // so they stay stable however long the memory stretches the access.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_dm) begin
                        r_state     <= GRANT_DM;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= dm_we;
                        r_mem_addr  <= dm_addr;
                        r_mem_wdata <= dm_wdata;
                    end else if (w_pick_if) begin
                        r_state     <= GRANT_IF;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= if_addr;
                        r_mem_wdata <= '0;
                    end
                end
                GRANT_IF, GRANT_DM: begin
                    // Access completes even if the requester has dropped.
                    if (mem_ready) begin
                        r_state   <= IDLE;
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_mem_req <= 1'b0;
                    r_mem_we  <= 1'b0;
                end
            endcase
        end
    end

`ifdef ARB_STARVE_GUARD_EN
    // Count data grants taken over a waiting fetch; a fetch grant clears it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_starve_cnt <= '0;
        end else if (r_state == IDLE) begin
            if (w_pick_dm && if_req && !w_starved)
                r_starve_cnt <= r_starve_cnt + 1'b1;
            else if (w_pick_if)
                r_starve_cnt <= '0;
        end
    end
`endif

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

    assign if_valid  = (r_state == GRANT_IF) & mem_ready;
    assign dm_valid  = (r_state == GRANT_DM) & mem_ready;
    assign if_rdata  = mem_rdata;
    assign dm_rdata  = mem_rdata;

    assign stall_f   = if_req & ~if_valid;
    assign stall_m   = dm_req & ~dm_valid;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Inputs change 1 time unit after a rising
// edge; outputs are sampled at the following falling edge.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_valid;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        stall_f;
    logic        stall_m;

    int errors = 0;
    int checks = 0;

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_valid(dm_valid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .stall_f(stall_f), .stall_m(stall_m)
    );

    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
        mem_rdata = 0; mem_ready = 0;
    endtask

    task automatic test_reset();
        reset = 0;
        if_req = 1; if_addr = 32'hAAAA_0000; dm_req = 1; dm_we = 1;
        dm_addr = 32'h5555_0000; dm_wdata = 32'h1234_5678; mem_ready = 1; mem_rdata = 0;
        repeat (2) next_cycle();
        @(negedge clk);
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
        checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata got %h want 0", mem_wdata); end
        checks++; if ({if_valid, dm_valid} !== 2'b00) begin errors++; $display("FAIL reset_valids got %b want 00", {if_valid, dm_valid}); end
        next_cycle();
        idle_inputs();
        reset = 1;
        next_cycle();
    endtask

    task automatic test_single_fetch();
        if_req = 1; if_addr = 32'h0000_0010;
        @(negedge clk);
        checks++; if (stall_f !== 1'b1) begin errors++; $display("FAIL fetch_stall_req_cycle got %b want 1", stall_f); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL fetch_mem_req_idle got %b want 0", mem_req); end
        next_cycle();
        mem_ready = 1; mem_rdata = 32'h0050_0093;
        @(negedge clk);
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL fetch_mem_req got %b want 1", mem_req); end
        checks++; if (mem_addr !== 32'h10) begin errors++; $display("FAIL fetch_mem_addr got %h want 00000010", mem_addr); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL fetch_mem_we got %b want 0", mem_we); end
        checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL fetch_if_valid got %b want 1", if_valid); end
        checks++; if (if_rdata !== 32'h0050_0093) begin errors++; $display("FAIL fetch_if_rdata got %h want 00500093", if_rdata); end
        checks++; if (dm_valid !== 1'b0) begin errors++; $display("FAIL fetch_dm_valid got %b want 0", dm_valid); end
        checks++; if (stall_f !== 1'b0) begin errors++; $display("FAIL fetch_stall_grant got %b want 0", stall_f); end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL fetch_back_idle got %b want 0", mem_req); end
        next_cycle();
    endtask

    task automatic test_collision();
        if_req = 1; if_addr = 32'h0000_0020;
        dm_req = 1; dm_we = 1; dm_addr = 32'h0000_0100; dm_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++; if ({stall_f, stall_m} !== 2'b11) begin errors++; $display("FAIL coll_stalls_idle got %b want 11", {stall_f, stall_m}); end
        next_cycle();
        mem_ready = 1;
        @(negedge clk);
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL coll_dm_we got %b want 1", mem_we); end
        checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL coll_dm_addr got %h want 00000100", mem_addr); end
        checks++; if (mem_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL coll_dm_wdata got %h want deadbeef", mem_wdata); end
        checks++; if ({if_valid, dm_valid} !== 2'b01) begin errors++; $display("FAIL coll_dm_valid got %b want 01", {if_valid, dm_valid}); end
        checks++; if (stall_f !== 1'b1) begin errors++; $display("FAIL coll_stall_f_dm got %b want 1", stall_f); end
        checks++; if (stall_m !== 1'b0) begin errors++; $display("FAIL coll_stall_m_dm got %b want 0", stall_m); end
        next_cycle();
        dm_req = 0; dm_we = 0; mem_ready = 0;
        @(negedge clk);
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL coll_bubble got %b want 0", mem_req); end
        checks++; if (stall_f !== 1'b1) begin errors++; $display("FAIL coll_stall_f_bubble got %b want 1", stall_f); end
        next_cycle();
        mem_ready = 1; mem_rdata = 32'h0000_0013;
        @(negedge clk);
        checks++; if (mem_addr !== 32'h20) begin errors++; $display("FAIL coll_if_addr got %h want 00000020", mem_addr); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL coll_if_we got %b want 0", mem_we); end
        checks++; if ({if_valid, dm_valid} !== 2'b10) begin errors++; $display("FAIL coll_if_valid got %b want 10", {if_valid, dm_valid}); end
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_wait_states();
        dm_req = 1; dm_we = 0; dm_addr = 32'h0000_0200;
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            if (i == 1) dm_req = 0;  // requester gives up; access must still finish
            dm_addr = 32'hFFFF_FFF0;
            @(negedge clk);
            checks++; if (mem_addr !== 32'h200) begin errors++; $display("FAIL wait_addr[%0d] got %h want 00000200", i, mem_addr); end
            checks++; if ({mem_req, dm_valid} !== 2'b10) begin errors++; $display("FAIL wait_req_valid[%0d] got %b want 10", i, {mem_req, dm_valid}); end
            checks++; if (stall_m !== (i == 0)) begin errors++; $display("FAIL wait_stall_m[%0d] got %b want %b", i, stall_m, (i == 0)); end
            next_cycle();
        end
        mem_ready = 1; mem_rdata = 32'h1234_5678;
        @(negedge clk);
        checks++; if (dm_valid !== 1'b1) begin errors++; $display("FAIL wait_done_valid got %b want 1", dm_valid); end
        checks++; if (dm_rdata !== 32'h1234_5678) begin errors++; $display("FAIL wait_done_rdata got %h want 12345678", dm_rdata); end
        next_cycle();
        @(negedge clk);
        checks++; if ({mem_req, if_valid, dm_valid} !== 3'b000) begin errors++; $display("FAIL idle_ready_ignored got %b want 000", {mem_req, if_valid, dm_valid}); end
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_reset_mid_grant();
        dm_req = 1; dm_we = 1; dm_addr = 32'h0000_0300; dm_wdata = 32'hCAFE_F00D;
        next_cycle();
        @(negedge clk);
        checks++; if ({mem_req, mem_we} !== 2'b11) begin errors++; $display("FAIL rst_mid_grant got %b want 11", {mem_req, mem_we}); end
        next_cycle();
        reset = 0;
        next_cycle();
        dm_req = 0;
        @(negedge clk);
        checks++; if ({mem_req, mem_we} !== 2'b00) begin errors++; $display("FAIL rst_mid_req got %b want 00", {mem_req, mem_we}); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mid_addr got %h want 0", mem_addr); end
        next_cycle();
        reset = 1; mem_ready = 1;
        @(negedge clk);
        checks++; if ({mem_req, dm_valid} !== 2'b00) begin errors++; $display("FAIL rst_mid_late_ready got %b want 00", {mem_req, dm_valid}); end
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_starvation();
        logic [9:0] exp_if;
        int g;
        reset = 0;
        next_cycle();
        reset = 1;
`ifdef ARB_STARVE_GUARD_EN
        exp_if = 10'b10000_10000;  // bit k = grant k is fetch (k from LSB)
`else
        exp_if = 10'b00000_00000;
`endif
        if_req = 1; if_addr = 32'h40; dm_req = 1; dm_we = 0; dm_addr = 32'h80; mem_ready = 1;
        g = 0;
        for (int c = 0; c < 40 && g < 10; c++) begin
            @(negedge clk);
            if (mem_req) begin
                checks++;
                if ({if_valid, dm_valid} !== (exp_if[g] ? 2'b10 : 2'b01)) begin
                    errors++;
                    $display("FAIL starve_grant[%0d] got if/dm %b want %b", g, {if_valid, dm_valid}, exp_if[g] ? 2'b10 : 2'b01);
                end
                g++;
            end
            next_cycle();
        end
        checks++; if (g != 10) begin errors++; $display("FAIL starve_grant_count got %0d want 10", g); end
        idle_inputs();
        next_cycle();
    endtask

    initial begin
        idle_inputs();
        reset = 0;
        test_reset();
        test_single_fetch();
        test_collision();
        test_wait_states();
        test_reset_mid_grant();
        test_starvation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
